// File: rtl/usb_bus_scheduler.sv
// usb_bus_scheduler: shares an FT245-style USB FIFO bus between the host read stream and two round-robin byte writers.
module usb_bus_scheduler #(
   parameter int RD_PULSE       = 2,
   parameter int WR_SETUP       = 1,
   parameter int WR_PULSE       = 2,
   parameter int RECOVERY       = 1,
   parameter int MAX_READ_BURST = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rxf_n,
   input  logic       txe_n,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_out_enable,
   output logic       rd_n,
   output logic       wr_n,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic [2:0] state_out
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WS   = 3'd2,
      S_WP   = 3'd3,
      S_REC  = 3'd4
   } state_t;

   localparam logic [3:0] C_RD  = 4'(RD_PULSE - 1);
   localparam logic [3:0] C_WS  = 4'(WR_SETUP - 1);
   localparam logic [3:0] C_WP  = 4'(WR_PULSE - 1);
   localparam logic [3:0] C_REC = 4'(RECOVERY - 1);
   localparam logic [7:0] C_MRB = 8'(MAX_READ_BURST);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [7:0] r_burst;
   logic       r_last;
   logic       r_grant;
   logic       r_rd_n;
   logic       r_wr_n;
   logic       r_doe;
   logic [7:0] r_dout;
   logic [7:0] r_rx;
   logic       r_rxv;
   logic       r_ack0;
   logic       r_ack1;

   logic w_pending;
   logic w_read;
   logic w_grant;
   logic w_done;

   assign w_pending = (req0 | req1) & ~txe_n;
   assign w_read    = ~rxf_n & (~w_pending | (r_burst < C_MRB));
   // On a tie the port that did not win last time gets the bus
   assign w_grant   = (req0 & req1) ? ~r_last : req1;
   assign w_done    = (r_cnt == 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_burst <= 8'd0;
         r_last  <= 1'b1;
         r_grant <= 1'b0;
         r_rd_n  <= 1'b1;
         r_wr_n  <= 1'b1;
         r_doe   <= 1'b0;
         r_dout  <= 8'd0;
         r_rx    <= 8'd0;
         r_rxv   <= 1'b0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
      end else begin
         r_rxv  <= 1'b0;
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_read) begin
                  r_state <= S_RD;
                  r_rd_n  <= 1'b0;
                  r_cnt   <= C_RD;
               end else if (w_pending) begin
                  r_state <= S_WS;
                  r_doe   <= 1'b1;
                  r_grant <= w_grant;
                  r_dout  <= w_grant ? data1 : data0;
                  r_cnt   <= C_WS;
               end
            end
            S_RD: begin
               if (!w_done) r_cnt <= r_cnt - 4'd1;
               else begin
                  r_state <= S_REC;
                  r_rd_n  <= 1'b1;
                  r_rx    <= data_in;
                  r_rxv   <= 1'b1;
                  r_burst <= (r_burst == 8'hFF) ? r_burst : r_burst + 8'd1;
                  r_cnt   <= C_REC;
               end
            end
            S_WS: begin
               if (!w_done) r_cnt <= r_cnt - 4'd1;
               else begin
                  r_state <= S_WP;
                  r_wr_n  <= 1'b0;
                  r_cnt   <= C_WP;
               end
            end
            S_WP: begin
               if (!w_done) r_cnt <= r_cnt - 4'd1;
               else begin
                  r_state <= S_REC;
                  r_wr_n  <= 1'b1;
                  r_doe   <= 1'b0;
                  r_ack0  <= ~r_grant;
                  r_ack1  <= r_grant;
                  r_burst <= 8'd0;
                  r_last  <= r_grant;
                  r_cnt   <= C_REC;
               end
            end
            S_REC: begin
               if (!w_done) r_cnt <= r_cnt - 4'd1;
               else r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_out        = r_dout;
   assign data_out_enable = r_doe;
   assign rd_n            = r_rd_n;
   assign wr_n            = r_wr_n;
   assign rx_data         = r_rx;
   assign rx_valid        = r_rxv;
   assign ack0            = r_ack0;
   assign ack1            = r_ack1;
   assign state_out       = r_state;
endmodule
